// File: rtl/customized_round_pack.sv
// Rounds a wide {sign, exponent, mantissa} product to IEEE single precision (round-to-nearest-even)
// and packs the result through a two-stage valid/ready pipeline.
module customized_round_pack #(
   parameter int exp_len          = 8,
   parameter int montissa_len_in  = 47,
   parameter int montissa_len_out = 23
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [exp_len+montissa_len_in:0]      in_data,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [exp_len+montissa_len_out:0]     out_data,
   output logic                                  out_inexact,
   output logic                                  out_overflow
);

   localparam int in_w      = 1 + exp_len + montissa_len_in;
   localparam int guard_pos = montissa_len_in - montissa_len_out - 1;
   localparam logic [exp_len-1:0] exp_max     = '1;
   localparam logic [exp_len-1:0] exp_pre_max = exp_max - 1'b1;
   localparam logic [montissa_len_out-1:0] qnan_frac = {1'b1, {(montissa_len_out-1){1'b0}}};

   typedef enum logic [1:0] {
      KIND_NORM,
      KIND_NAN,
      KIND_INF,
      KIND_ZERO
   } kind_t;

   logic                          in_sign;
   logic [exp_len-1:0]            in_exp;
   logic [montissa_len_in-1:0]    in_frac;
   logic [montissa_len_out-1:0]   keep;
   logic                          guard;
   logic                          sticky;
   logic                          round_up;
   logic [montissa_len_out:0]     mant_r;
   kind_t                         kind_d;
   logic                          inexact_d;

   logic                          s1_valid;
   logic                          s1_sign;
   logic [exp_len-1:0]            s1_exp;
   logic [montissa_len_out:0]     s1_mant;
   kind_t                         s1_kind;
   logic                          s1_inexact;

   logic                          s2_load;
   logic                          s1_load;
   logic [exp_len-1:0]            exp_inc;
   logic [exp_len+montissa_len_out:0] s2_data_d;
   logic                          s2_inexact_d;
   logic                          s2_overflow_d;

   assign s2_load  = s1_valid && (!out_valid || out_ready);
   assign in_ready = !s1_valid || s2_load;
   assign s1_load  = in_valid && in_ready;

   assign in_sign = in_data[in_w-1];
   assign in_exp  = in_data[in_w-2 -: exp_len];
   assign in_frac = in_data[montissa_len_in-1:0];

   // Stage 1 decode: round the mantissa and classify the operand.
   always_comb begin
      keep      = in_frac[montissa_len_in-1 -: montissa_len_out];
      guard     = in_frac[guard_pos];
      sticky    = |in_frac[guard_pos-1:0];
      round_up  = guard & (sticky | keep[0]);
      mant_r    = {1'b0, keep} + {{montissa_len_out{1'b0}}, round_up};
      kind_d    = KIND_NORM;
      inexact_d = guard | sticky;
      if (in_exp == exp_max) begin
         kind_d    = (in_frac != '0) ? KIND_NAN : KIND_INF;
         inexact_d = 1'b0;
      end else if (in_exp == '0) begin
         kind_d    = KIND_ZERO;
         inexact_d = (in_frac != '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_sign    <= 1'b0;
         s1_exp     <= '0;
         s1_mant    <= '0;
         s1_kind    <= KIND_NORM;
         s1_inexact <= 1'b0;
      end else begin
         if (s1_load) begin
            s1_valid   <= 1'b1;
            s1_sign    <= in_sign;
            s1_exp     <= in_exp;
            s1_mant    <= mant_r;
            s1_kind    <= kind_d;
            s1_inexact <= inexact_d;
         end else if (s2_load) begin
            s1_valid <= 1'b0;
         end
      end
   end

   // Stage 2 pack: a rounding carry bumps the exponent and may saturate to infinity.
   always_comb begin
      exp_inc       = s1_exp + {{(exp_len-1){1'b0}}, 1'b1};
      s2_data_d     = {s1_sign, s1_exp, s1_mant[montissa_len_out-1:0]};
      s2_inexact_d  = s1_inexact;
      s2_overflow_d = 1'b0;
      case (s1_kind)
         KIND_NAN:  s2_data_d = {s1_sign, exp_max, qnan_frac};
         KIND_INF:  s2_data_d = {s1_sign, exp_max, {montissa_len_out{1'b0}}};
         KIND_ZERO: s2_data_d = {s1_sign, {(exp_len+montissa_len_out){1'b0}}};
         default: begin
            if (s1_mant[montissa_len_out]) begin
               s2_data_d = {s1_sign, exp_inc, {montissa_len_out{1'b0}}};
               if (s1_exp == exp_pre_max) begin
                  s2_overflow_d = 1'b1;
                  s2_inexact_d  = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_data     <= '0;
         out_inexact  <= 1'b0;
         out_overflow <= 1'b0;
      end else begin
         if (s2_load) begin
            out_valid    <= 1'b1;
            out_data     <= s2_data_d;
            out_inexact  <= s2_inexact_d;
            out_overflow <= s2_overflow_d;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_customized_round_pack.sv
// Self-checking bench for customized_round_pack: directed corner cases plus randomized traffic
// scored against an arithmetic rounding model.
module tb_customized_round_pack;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [55:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic        out_inexact;
   logic        out_overflow;

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [33:0] exp_q[$];
   logic        seen_valid;
   logic        seen_in_ready;
   logic        last_accepted;
   logic        held_valid = 1'b0;
   logic [33:0] held_word = '0;

   customized_round_pack dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_inexact  (out_inexact),
      .out_overflow (out_overflow)
   );

   always #5 clk = ~clk;

   // Reference: treat 1.frac as an integer, round to 24 significant bits by remainder comparison.
   function automatic logic [33:0] ref_model(input logic [55:0] d);
      logic            s;
      int              e;
      longint unsigned m, q, r, half;
      logic            inexact;
      s = d[55];
      e = int'(d[54:47]);
      if (e == 255) return (d[46:0] != 0) ? {2'b00, s, 8'hFF, 23'h400000} : {2'b00, s, 8'hFF, 23'h0};
      if (e == 0) return {(d[46:0] != 0), 1'b0, s, 31'h0};
      m    = (64'd1 << 47) + {17'd0, d[46:0]};
      q    = m / (64'd1 << 24);
      r    = m % (64'd1 << 24);
      half = 64'd1 << 23;
      inexact = (r != 0);
      if (r > half || (r == half && q[0])) q = q + 1;
      if (q == (64'd1 << 24)) begin
         q = q / 2;
         e = e + 1;
      end
      if (e >= 255) return {2'b11, s, 8'hFF, 23'h0};
      return {inexact, 1'b0, s, e[7:0], q[22:0]};
   endfunction

   function automatic logic [55:0] rand_item();
      logic [7:0]  e;
      logic [46:0] f;
      case ($urandom_range(0, 9))
         0:       e = 8'd0;
         1:       e = 8'd255;
         2:       e = 8'd254;
         3:       e = 8'd126;
         4:       e = 8'd1;
         default: e = 8'($urandom_range(1, 254));
      endcase
      case ($urandom_range(0, 3))
         0:       f = '1;
         1:       f = {23'($urandom), 1'b1, 23'd0};
         default: f = 47'({$urandom(), $urandom()});
      endcase
      return {1'($urandom), e, f};
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_compared++;
      assert (obs === expv) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One cycle: drive at negedge, observe 1ns later, score transfers, then ride the posedge.
   task automatic apply_stimulus(input logic iv, input logic [55:0] d, input logic ordy,
                                 input logic use_exp, input logic [33:0] expw);
      logic [33:0] word;
      @(negedge clk);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      #1;
      seen_valid    = out_valid;
      seen_in_ready = in_ready;
      last_accepted = iv && in_ready;
      word = {out_inexact, out_overflow, out_data};
      if (held_valid) check_output("hold_stable", {30'd0, out_valid, word}, {30'd0, 1'b1, held_word});
      if (last_accepted) exp_q.push_back(use_exp ? expw : ref_model(d));
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) check_output("extra_output", {63'd0, out_valid}, 64'd0);
         else check_output("out_word", {30'd0, word}, {30'd0, exp_q.pop_front()});
      end
      held_valid = out_valid && !out_ready;
      held_word  = word;
      @(posedge clk);
   endtask

   task automatic idle(input logic ordy);
      apply_stimulus(1'b0, {$urandom(), 24'($urandom())}, ordy, 1'b0, '0);
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && exp_q.size() > 0; i++) idle(1'b1);
      check_output("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [55:0] items[4];
      int          idx;
      int          n_acc;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      check_output("reset_state", {30'd0, out_valid, out_inexact, out_overflow, out_data}, 64'd0);
      rst_n = 1'b1;
      #1;
      check_output("reset_in_ready", {63'd0, in_ready}, 64'd1);

      // 1.0 passthrough with latency check
      apply_stimulus(1'b1, {1'b0, 8'd127, 47'h0}, 1'b1, 1'b1, {2'b00, 32'h3F800000});
      idle(1'b1);
      check_output("latency_c1", {63'd0, seen_valid}, 64'd0);
      idle(1'b1);
      check_output("latency_c2", {63'd0, seen_valid}, 64'd1);

      // Ties and rounding carries
      apply_stimulus(1'b1, {1'b0, 8'd127, 47'h0000_0080_0000}, 1'b1, 1'b1, {2'b10, 32'h3F800000});
      apply_stimulus(1'b1, {1'b0, 8'd127, 47'h0000_0180_0000}, 1'b1, 1'b1, {2'b10, 32'h3F800002});
      apply_stimulus(1'b1, {1'b0, 8'd254, {47{1'b1}}},         1'b1, 1'b1, {2'b11, 32'h7F800000});
      apply_stimulus(1'b1, {1'b0, 8'd126, {47{1'b1}}},         1'b1, 1'b1, {2'b10, 32'h3F800000});
      // Special operands
      apply_stimulus(1'b1, {1'b1, 8'd255, 47'h1},              1'b1, 1'b1, {2'b00, 32'hFFC00000});
      apply_stimulus(1'b1, {1'b0, 8'd255, 47'h0},              1'b1, 1'b1, {2'b00, 32'h7F800000});
      apply_stimulus(1'b1, {1'b1, 8'd0,   47'h5},              1'b1, 1'b1, {2'b10, 32'h80000000});
      drain();

      // Backpressure: four items, consumer stalled for three cycles
      for (int i = 0; i < 4; i++) items[i] = {1'b0, 8'($urandom_range(1, 253)), 47'({$urandom(), $urandom()})};
      idx   = 0;
      n_acc = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (idx >= 4 && exp_q.size() == 0) break;
         apply_stimulus(idx < 4, (idx < 4) ? items[idx] : 56'd0, cyc >= 3, 1'b0, '0);
         if (last_accepted) begin
            idx++;
            n_acc++;
         end
         if (cyc == 2) begin
            check_output("full_in_ready", {63'd0, seen_in_ready}, 64'd0);
            check_output("full_accepted", 64'(n_acc), 64'd2);
         end
      end
      check_output("stream_accepted", 64'(idx), 64'd4);
      check_output("stream_drained", 64'(exp_q.size()), 64'd0);

      // Reset with two items in flight
      apply_stimulus(1'b1, rand_item(), 1'b0, 1'b0, '0);
      apply_stimulus(1'b1, rand_item(), 1'b0, 1'b0, '0);
      check_output("inflight_accepted", 64'(exp_q.size()), 64'd2);
      @(negedge clk);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      check_output("midreset_outputs", {31'd0, out_valid, out_data}, 64'd0);
      exp_q.delete();
      held_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         idle(1'b1);
         check_output("post_reset_quiet", {63'd0, seen_valid}, 64'd0);
      end

      // Randomized traffic with random backpressure
      for (int i = 0; i < 300; i++)
         apply_stimulus($urandom_range(0, 3) != 0, rand_item(), $urandom_range(0, 9) < 7, 1'b0, '0);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
